// File: rtl/serial_add_ctrl.sv
// serial_add_ctrl: bit-serial LSB-first adder controller driving a two-half-adder full adder
module serial_add_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             carry_out
);
    localparam int CW = $clog2(WIDTH) + 1;
    localparam logic [CW-1:0] last_cnt = CW'(WIDTH - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] acc_next;
    logic             c;
    logic [CW-1:0]    cnt;
    logic             s1;
    logic             c1;
    logic             c2;
    logic             bit_sum;
    logic             bit_carry;

    half_adder ha1 (.x(a_sh[0]), .y(b_sh[0]), .s(s1),      .co(c1));
    half_adder ha2 (.x(s1),      .y(c),       .s(bit_sum), .co(c2));

    assign bit_carry = c1 | c2;
    // new bit enters at the MSB so that after WIDTH edges bit 0 sits at the LSB
    assign acc_next  = (acc >> 1) | (WIDTH'(bit_sum) << (WIDTH - 1));

    // control FSM with registered handshake, operand shifters and result registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            a_sh      <= '0;
            b_sh      <= '0;
            acc       <= '0;
            c         <= 1'b0;
            cnt       <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            sum       <= '0;
            carry_out <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        a_sh  <= a;
                        b_sh  <= b;
                        c     <= 1'b0;
                        cnt   <= '0;
                        acc   <= '0;
                        busy  <= 1'b1;
                        state <= RUN;
                    end
                end
                RUN: begin
                    acc  <= acc_next;
                    c    <= bit_carry;
                    a_sh <= a_sh >> 1;
                    b_sh <= b_sh >> 1;
                    cnt  <= cnt + CW'(1);
                    if (cnt == last_cnt) begin
                        sum       <= acc_next;
                        carry_out <= bit_carry;
                        done      <= 1'b1;
                        state     <= DONE;
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

module half_adder (
    input  logic x,
    input  logic y,
    output logic s,
    output logic co
);
    assign s  = x ^ y;
    assign co = x & y;
endmodule

// File: tb/tb_serial_add_ctrl.sv
// tb_serial_add_ctrl: self-checking bench for the bit-serial adder controller (WIDTH=8 and WIDTH=1)
module tb_serial_add_ctrl;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic [7:0] a = '0;
    logic [7:0] b = '0;
    logic       busy;
    logic       done;
    logic [7:0] sum;
    logic       carry_out;

    logic       start1 = 1'b0;
    logic [0:0] a1 = '0;
    logic [0:0] b1 = '0;
    logic       busy1;
    logic       done1;
    logic [0:0] sum1;
    logic       carry1;

    int         checks = 0;
    int         errors = 0;
    logic [7:0] prev_s = '0;
    logic       prev_c = 1'b0;

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] s;
        logic       co;
    } vec_t;

    vec_t vecs[5];

    always #5 clk = ~clk;

    serial_add_ctrl #(.WIDTH(8)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b),
        .busy(busy), .done(done), .sum(sum), .carry_out(carry_out)
    );

    serial_add_ctrl #(.WIDTH(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .start(start1), .a(a1), .b(b1),
        .busy(busy1), .done(done1), .sum(sum1), .carry_out(carry1)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string nm, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, got, exp);
        end
    endtask

    // one WIDTH=8 add; noise=1 keeps start high with 0xFF operands while busy
    task automatic op8(input logic [7:0] x, input logic [7:0] y, input bit noise,
                       output logic [7:0] s, output logic co);
        logic [8:0] ref9;
        int lat;
        int bcnt;
        bit held;
        ref9 = {1'b0, x} + {1'b0, y};
        a = x;
        b = y;
        start = 1'b1;
        tick;
        start = noise;
        a = noise ? 8'hFF : 8'($urandom);
        b = noise ? 8'hFF : 8'($urandom);
        lat = 0;
        bcnt = 0;
        held = 1'b1;
        while (!done && lat < 40) begin
            if (busy) bcnt++;
            if ({carry_out, sum} !== {prev_c, prev_s}) held = 1'b0;
            tick;
            lat++;
        end
        if (busy) bcnt++;
        check("latency", lat, 8);
        check("busy_cycles", bcnt, 9);
        check("result_hold", held, 1);
        check("result_model", {carry_out, sum}, ref9);
        s = sum;
        co = carry_out;
        tick;
        check("done_pulse", {busy, done}, 2'b00);
        start = 1'b0;
        prev_s = ref9[7:0];
        prev_c = ref9[8];
    endtask

    // one WIDTH=1 add
    task automatic op1(input logic x, input logic y);
        logic [1:0] r;
        int lat;
        r = {1'b0, x} + {1'b0, y};
        a1 = x;
        b1 = y;
        start1 = 1'b1;
        tick;
        start1 = 1'b0;
        a1 = ~x;
        b1 = ~y;
        lat = 0;
        while (!done1 && lat < 10) begin
            tick;
            lat++;
        end
        check("w1_latency", lat, 1);
        check("w1_result", {carry1, sum1}, r);
        tick;
        check("w1_idle", {busy1, done1}, 2'b00);
    endtask

    initial begin
        logic [7:0] s;
        logic       co;
        bit         ok;
        logic [7:0] ba[4];
        logic [7:0] bb[4];
        int         acc_cyc[$];
        int         ndone;
        logic       pbusy;

        vecs[0] = '{8'hFF, 8'h01, 8'h00, 1'b1};
        vecs[1] = '{8'h5A, 8'hA5, 8'hFF, 1'b0};
        vecs[2] = '{8'h3C, 8'h0F, 8'h4B, 1'b0};
        vecs[3] = '{8'h00, 8'h00, 8'h00, 1'b0};
        vecs[4] = '{8'hFF, 8'hFF, 8'hFE, 1'b1};

        rst_n = 1'b0;
        tick;
        tick;
        rst_n = 1'b1;
        check("reset_state", {busy, done, carry_out, sum}, 11'h0);
        check("reset_state_w1", {busy1, done1, carry1, sum1}, 4'h0);
        ok = 1'b1;
        repeat (10) begin
            tick;
            if ({busy, done, carry_out, sum} !== 11'h0) ok = 1'b0;
        end
        check("idle_quiet", ok, 1);

        for (int i = 0; i < 5; i++) begin
            op8(vecs[i].a, vecs[i].b, 1'b0, s, co);
            check($sformatf("vec%0d", i), {co, s}, {vecs[i].co, vecs[i].s});
        end

        op8(8'h01, 8'h02, 1'b1, s, co);
        check("busy_ignore", {co, s}, 9'h003);
        ok = 1'b1;
        repeat (4) begin
            tick;
            if (busy || done) ok = 1'b0;
        end
        check("no_second_op", ok, 1);

        a = 8'h80;
        b = 8'h80;
        start = 1'b1;
        tick;
        start = 1'b0;
        repeat (3) tick;
        rst_n = 1'b0;
        tick;
        check("mid_reset", {busy, done, carry_out, sum}, 11'h0);
        rst_n = 1'b1;
        ok = 1'b1;
        repeat (12) begin
            tick;
            if (busy || done) ok = 1'b0;
        end
        check("mid_reset_no_done", ok, 1);
        prev_s = '0;
        prev_c = 1'b0;
        op8(8'h80, 8'h80, 1'b0, s, co);
        check("after_reset", {co, s}, 9'h100);

        rst_n = 1'b0;
        start = 1'b1;
        tick;
        check("reset_wins", busy, 0);
        rst_n = 1'b1;
        start = 1'b0;
        tick;
        check("reset_wins_idle", busy, 0);
        prev_s = '0;
        prev_c = 1'b0;

        for (int k = 0; k < 4; k++) begin
            ba[k] = 8'($urandom);
            bb[k] = 8'($urandom);
        end
        ndone = 0;
        pbusy = busy;
        a = ba[0];
        b = bb[0];
        start = 1'b1;
        for (int cyc = 0; cyc < 45 && ndone < 4; cyc++) begin
            tick;
            if (busy && !pbusy) acc_cyc.push_back(cyc);
            pbusy = busy;
            if (done) begin
                check($sformatf("b2b_res%0d", ndone), {carry_out, sum}, {1'b0, ba[ndone]} + {1'b0, bb[ndone]});
                ndone++;
                if (ndone < 4) begin
                    a = ba[ndone];
                    b = bb[ndone];
                end
            end
        end
        start = 1'b0;
        check("b2b_ops", ndone, 4);
        check("b2b_accepts", acc_cyc.size(), 4);
        for (int k = 1; k < acc_cyc.size(); k++)
            check($sformatf("b2b_gap%0d", k), acc_cyc[k] - acc_cyc[k-1], 10);
        prev_s = sum;
        prev_c = carry_out;
        tick;
        tick;

        for (int i = 0; i < 1000; i++)
            op8(8'($urandom), 8'($urandom), 1'b0, s, co);
        for (int i = 0; i < 1000; i++)
            op1(1'($urandom), 1'($urandom));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
